// File: rtl/cipher_arbiter.sv
// Round-robin arbiter sharing one XOR cipher stage among NUM_REQ requesters, with a per-requester key table.
// Optional per-requester saturating transfer counters: define CIPHER_ARB_GRANT_CNT_EN.
module cipher_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_mode,
   input  logic                        key_wr_en,
   input  logic [IDX_W-1:0]            key_wr_idx,
   input  logic [DATA_W-1:0]           key_wr_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [IDX_W-1:0]            out_id,
   output logic                        out_mode
`ifdef CIPHER_ARB_GRANT_CNT_EN
   ,
   output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

   // state   | meaning
   // S_EMPTY | output stage holds nothing, out_valid=0
   // S_FULL  | output stage holds a result, out_valid=1
   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} stage_t;

   stage_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [DATA_W-1:0]   key_q [NUM_REQ];
   logic [DATA_W-1:0]   out_data_q;
   logic [IDX_W-1:0]    out_id_q;
   logic                out_mode_q;

   logic                gnt_found;
   logic [IDX_W-1:0]    gnt_idx;
   logic [IDX_W:0]      cand;
   logic                can_accept;
   logic                fire;

   // Upward search from rr_ptr with wrap; cand carries one spare bit so the wrap compare cannot overflow.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      can_accept = (state_q == S_EMPTY) || out_ready;
      req_ready  = '0;
      fire       = 1'b0;
      if (gnt_found && can_accept) begin
         req_ready[gnt_idx] = 1'b1;
         fire               = 1'b1;
      end
      case (state_q)
         S_EMPTY: if (fire) state_d = S_FULL;
         S_FULL: begin
            if (fire)           state_d = S_FULL;
            else if (out_ready) state_d = S_EMPTY;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_EMPTY;
      else        state_q <= state_d;
   end

   // The stage loads with the key value from before any same-cycle key write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q <= '0;
         out_id_q   <= '0;
         out_mode_q <= 1'b0;
         rr_ptr_q   <= '0;
      end else if (fire) begin
         out_data_q <= req_data[gnt_idx*DATA_W +: DATA_W] ^ key_q[gnt_idx];
         out_id_q   <= gnt_idx;
         out_mode_q <= req_mode[gnt_idx];
         rr_ptr_q   <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REQ; k++) key_q[k] <= '0;
      end else if (key_wr_en && ({1'b0, key_wr_idx} < (IDX_W+1)'(NUM_REQ))) begin
         key_q[key_wr_idx] <= key_wr_data;
      end
   end

   assign out_valid = (state_q == S_FULL);
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign out_mode  = out_mode_q;

`ifdef CIPHER_ARB_GRANT_CNT_EN
   logic [15:0] cnt_q [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
      end else if (fire && (cnt_q[gnt_idx] != 16'hFFFF)) begin
         cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 16'd1;
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int k = 0; k < NUM_REQ; k++) grant_cnt[k*16 +: 16] = cnt_q[k];
   end
`endif

endmodule

// File: doc/cipher_arbiter.md
# cipher_arbiter

Round-robin arbiter and sequencer that shares a single XOR cipher stage among NUM_REQ requesters. Each requester owns a key slot in an internal key table, written through a configuration port. Granted data is XORed with the requester's key and registered into a one-entry output stage with a valid/ready handshake. The block sits between the per-channel sources and the downstream consumer of encrypted or decrypted bytes.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, data and key width in bits
- IDX_W, $clog2(NUM_REQ), requester index width
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester valid
- req_ready  output  NUM_REQ  per-requester ready; one-hot or zero
- req_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_mode  input  NUM_REQ  tag per requester: 0 = encrypt, 1 = decrypt; passed through unchanged
- key_wr_en  input  1  key table write strobe
- key_wr_idx  input  IDX_W  key slot to write; values ≥ NUM_REQ are ignored
- key_wr_data  input  DATA_W  new key
- out_valid  output  1  output stage holds a result
- out_ready  input  1  consumer accepts the result
- out_data  output  DATA_W  req_data XOR key[granted]
- out_id  output  IDX_W  index of the granted requester
- out_mode  output  1  req_mode of the granted requester

## Operation
- Key table: NUM_REQ registers of DATA_W bits, all 0 after reset. A write takes effect at the clock edge where key_wr_en=1.
- Output stage: two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = EMPTY or (FULL and out_ready).
- Arbitration: among the requesters with req_valid=1, grant the first one found when searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0. Set req_ready[g]=1 only if can_accept; all other req_ready bits are 0.
- Transfer fires when req_valid[g] and req_ready[g] are both 1. At that clock edge:
  - the output stage loads out_data = req_data[g] XOR key[g], out_id = g, out_mode = req_mode[g], and becomes FULL;
  - rr_ptr becomes (g+1) mod NUM_REQ.
- A FULL stage with out_ready=1 and no transfer becomes EMPTY.
- A FULL stage with out_ready=0 holds out_data, out_id and out_mode stable.
- rr_ptr changes only on a transfer. A requester that withdraws req_valid before it is granted loses nothing, and the block does not raise an error.
- Key write and transfer in the same cycle to the same slot: the transfer uses the old key, and the new key applies from the next cycle.
- Encrypt and decrypt are the same XOR. req_mode is a tag only and does not change the datapath.

## Timing
- Reset values (asynchronous on rst_n=0): out_valid=0, out_data=0, out_id=0, out_mode=0, rr_ptr=0, key table=0, COUNTERS=0.
- req_ready is combinational from req_valid, rr_ptr, the stage state and out_ready. No output depends combinationally on req_data.
- Latency: out_valid rises 1 cycle after the transfer edge.
- Throughput: 1 transfer per cycle while out_ready=1.
- Reset asserted mid-transfer: the in-flight result is discarded, and no output is produced after rst_n deasserts until a new transfer fires.

## Configuration
- CIPHER_ARB_GRANT_CNT_EN
  - Defined: adds output grant_cnt (input? no, output), width NUM_REQ*16. It holds per-requester saturating counters of transfers, incremented on each transfer of index g and held at 16'hFFFF once reached. All counters are cleared by reset.
  - Undefined: the port and the counters are absent. Arbitration behaviour is identical.

## Test plan
- Key write slot 1 = 8'hA5, then requester 1 sends 8'h3C with out_ready=1 → req_ready=4'b0010, and the next cycle gives out_valid=1, out_data=8'h99, out_id=1.
- All four valid continuously, all keys 0, out_ready=1 → out_id sequence is 0,1,2,3,0,… with one result per cycle.
- out_ready=0 for 3 cycles while FULL → req_ready=0, and out_data, out_id and out_mode are held. Releasing out_ready gives the next grant in the same cycle.
- Same-cycle key write to slot 2 (8'hFF) and transfer from requester 2 with 8'h0F, where the old key is 8'h00 → out_data=8'h0F. The next transfer from requester 2 with 8'h0F gives 8'hF0.
- Round trip: send 8'h5A with mode=0 using key 8'h3C, getting 8'h66. Feed 8'h66 back with mode=1 → out_data=8'h5A, out_mode=1.
- rst_n pulsed low while FULL → out_valid=0 and rr_ptr=0 immediately (without a clock edge), and the key table reads 0.
